// File: rtl/id_stage_if.sv
// Shared next-PC select type and the fetch <-> decode link: IF/ID buffer
// forward, pc_mux/stall/flush back to fetch.
package core_pkg;
  typedef enum logic [0:0] {
    NEXTPC     = 1'b0,
    ALU_RESULT = 1'b1
  } pc_mux;
endpackage

interface id_stage_if;
  import core_pkg::*;

  logic        instr_valid_ip;
  logic [31:0] instr_data_ip;
  logic [31:0] instr_pc_addr_ip;
  pc_mux       pc_mux_op;
  logic        stall_op;
  logic        flush_op;

  modport master (
    output instr_valid_ip, instr_data_ip, instr_pc_addr_ip,
    input  pc_mux_op, stall_op, flush_op
  );

  modport slave (
    input  instr_valid_ip, instr_data_ip, instr_pc_addr_ip,
    output pc_mux_op, stall_op, flush_op
  );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: decode, register file with write-first bypass,
// load-use stall, redirect tracking, and the registered ID/EX buffer.
module id_stage
  import core_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int RESET_REGS = 1
) (
  input  logic        clock,
  input  logic        reset,
  id_stage_if.slave   fetch_bus,
  input  logic        alu_result_valid_ip,
  input  logic        wb_we_ip,
  input  logic [4:0]  wb_rd_ip,
  input  logic [31:0] wb_data_ip,
  output logic        id_valid_op,
  output logic [31:0] pc_addr_op,
  output logic [31:0] rs1_data_op,
  output logic [31:0] rs2_data_op,
  output logic [31:0] imm_op,
  output logic [4:0]  rd_op,
  output logic [3:0]  alu_op_op,
  output logic [2:0]  funct3_op,
  output logic        alu_src_imm_op,
  output logic        mem_read_op,
  output logic        mem_write_op,
  output logic        reg_write_op,
  output logic        is_ctrl_op
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    WAIT_TGT = 2'b01,
    DRAIN    = 2'b10
  } state_e;

  state_e      state_r;
  logic [31:0] regs_r [NUM_REGS];

  logic [31:0] instr_s;
  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [4:0]  rs1_s, rs2_s, rd_s;
  logic        legal_s, uses_rs1_s, uses_rs2_s, is_ctrl_s;
  logic        alu_src_imm_s, mem_read_s, mem_write_s, reg_write_s;
  logic [31:0] imm_s;
  logic [3:0]  alu_op_s;
  logic [31:0] rs1_val_s, rs2_val_s;
  logic        live_s, illegal_s, hazard_s, issue_s;
  pc_mux       pc_mux_s;

  assign instr_s  = fetch_bus.instr_data_ip;
  assign opcode_s = instr_s[6:0];
  assign funct3_s = instr_s[14:12];
  assign rs1_s    = instr_s[19:15];
  assign rs2_s    = instr_s[24:20];
  assign rd_s     = instr_s[11:7];

  // Register read: x0 is zero, a same-cycle write-back to the register wins.
  function automatic logic [31:0] read_reg(input logic [4:0] idx);
    logic [31:0] val;
    if (idx == 5'd0) begin
      val = 32'd0;
    end else if (wb_we_ip && (wb_rd_ip == idx)) begin
      val = wb_data_ip;
    end else begin
      val = regs_r[idx];
    end
    return val;
  endfunction

  // Opcode decode: legality, operand usage, immediate and control bits.
  always_comb begin
    legal_s       = 1'b0;
    uses_rs1_s    = 1'b0;
    uses_rs2_s    = 1'b0;
    is_ctrl_s     = 1'b0;
    alu_src_imm_s = 1'b0;
    mem_read_s    = 1'b0;
    mem_write_s   = 1'b0;
    reg_write_s   = 1'b0;
    imm_s         = 32'd0;
    alu_op_s      = 4'd0;
    case (opcode_s)
      OPC_LUI, OPC_AUIPC: begin
        legal_s       = 1'b1;
        alu_src_imm_s = 1'b1;
        reg_write_s   = 1'b1;
        imm_s         = {instr_s[31:12], 12'd0};
      end
      OPC_JAL: begin
        legal_s       = 1'b1;
        is_ctrl_s     = 1'b1;
        alu_src_imm_s = 1'b1;
        reg_write_s   = 1'b1;
        imm_s = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12],
                 instr_s[20], instr_s[30:21], 1'b0};
      end
      OPC_JALR: begin
        legal_s       = 1'b1;
        is_ctrl_s     = 1'b1;
        uses_rs1_s    = 1'b1;
        alu_src_imm_s = 1'b1;
        reg_write_s   = 1'b1;
        imm_s         = {{20{instr_s[31]}}, instr_s[31:20]};
      end
      OPC_BRANCH: begin
        legal_s    = 1'b1;
        is_ctrl_s  = 1'b1;
        uses_rs1_s = 1'b1;
        uses_rs2_s = 1'b1;
        imm_s = {{19{instr_s[31]}}, instr_s[31], instr_s[7],
                 instr_s[30:25], instr_s[11:8], 1'b0};
      end
      OPC_LOAD: begin
        legal_s       = 1'b1;
        uses_rs1_s    = 1'b1;
        alu_src_imm_s = 1'b1;
        mem_read_s    = 1'b1;
        reg_write_s   = 1'b1;
        imm_s         = {{20{instr_s[31]}}, instr_s[31:20]};
      end
      OPC_STORE: begin
        legal_s       = 1'b1;
        uses_rs1_s    = 1'b1;
        uses_rs2_s    = 1'b1;
        alu_src_imm_s = 1'b1;
        mem_write_s   = 1'b1;
        imm_s = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
      end
      OPC_OPIMM: begin
        legal_s       = 1'b1;
        uses_rs1_s    = 1'b1;
        alu_src_imm_s = 1'b1;
        reg_write_s   = 1'b1;
        imm_s         = {{20{instr_s[31]}}, instr_s[31:20]};
        // Only shifts carry funct7[5] (SRAI vs SRLI); elsewhere it is imm.
        alu_op_s = {(funct3_s == 3'b101) ? instr_s[30] : 1'b0, funct3_s};
      end
      OPC_OP: begin
        legal_s     = 1'b1;
        uses_rs1_s  = 1'b1;
        uses_rs2_s  = 1'b1;
        reg_write_s = 1'b1;
        alu_op_s    = {instr_s[30], funct3_s};
      end
      default: begin
        legal_s = 1'b0;
      end
    endcase
  end

  assign rs1_val_s = read_reg(rs1_s);
  assign rs2_val_s = read_reg(rs2_s);

  // Hazard, flush and next-PC select; squashed instructions are ignored.
  always_comb begin
    live_s    = fetch_bus.instr_valid_ip && (state_r == RUN) && !reset;
    illegal_s = live_s && !legal_s;
    hazard_s  = live_s && legal_s && mem_read_op && (rd_op != 5'd0) &&
                ((uses_rs1_s && (rs1_s == rd_op)) ||
                 (uses_rs2_s && (rs2_s == rd_op)));
    issue_s   = live_s && legal_s && !hazard_s;
    if (reset) begin
      pc_mux_s = NEXTPC;
    end else if (state_r == WAIT_TGT) begin
      pc_mux_s = ALU_RESULT;
    end else if (issue_s && is_ctrl_s) begin
      pc_mux_s = ALU_RESULT;
    end else begin
      pc_mux_s = NEXTPC;
    end
  end

  assign fetch_bus.pc_mux_op = pc_mux_s;
  assign fetch_bus.stall_op  = hazard_s;
  assign fetch_bus.flush_op  = illegal_s;

  // Register file write port; x0 writes are dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      if (RESET_REGS == 1) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          regs_r[i] <= 32'd0;
        end
      end
    end else if (wb_we_ip && (wb_rd_ip != 5'd0)) begin
      regs_r[wb_rd_ip] <= wb_data_ip;
    end
  end

  // Redirect FSM and ID/EX buffer; anything not issued becomes a bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= RUN;
      id_valid_op    <= 1'b0;
      pc_addr_op     <= 32'd0;
      rs1_data_op    <= 32'd0;
      rs2_data_op    <= 32'd0;
      imm_op         <= 32'd0;
      rd_op          <= 5'd0;
      alu_op_op      <= 4'd0;
      funct3_op      <= 3'd0;
      alu_src_imm_op <= 1'b0;
      mem_read_op    <= 1'b0;
      mem_write_op   <= 1'b0;
      reg_write_op   <= 1'b0;
      is_ctrl_op     <= 1'b0;
    end else begin
      case (state_r)
        RUN:      if (issue_s && is_ctrl_s) state_r <= WAIT_TGT;
        WAIT_TGT: if (alu_result_valid_ip) state_r <= DRAIN;
        DRAIN:    state_r <= RUN;
        default:  state_r <= RUN;
      endcase
      if (issue_s) begin
        id_valid_op    <= 1'b1;
        pc_addr_op     <= fetch_bus.instr_pc_addr_ip;
        rs1_data_op    <= rs1_val_s;
        rs2_data_op    <= rs2_val_s;
        imm_op         <= imm_s;
        rd_op          <= reg_write_s ? rd_s : 5'd0;
        alu_op_op      <= alu_op_s;
        funct3_op      <= funct3_s;
        alu_src_imm_op <= alu_src_imm_s;
        mem_read_op    <= mem_read_s;
        mem_write_op   <= mem_write_s;
        reg_write_op   <= reg_write_s;
        is_ctrl_op     <= is_ctrl_s;
      end else begin
        id_valid_op    <= 1'b0;
        pc_addr_op     <= 32'd0;
        rs1_data_op    <= 32'd0;
        rs2_data_op    <= 32'd0;
        imm_op         <= 32'd0;
        rd_op          <= 5'd0;
        alu_op_op      <= 4'd0;
        funct3_op      <= 3'd0;
        alu_src_imm_op <= 1'b0;
        mem_read_op    <= 1'b0;
        mem_write_op   <= 1'b0;
        reg_write_op   <= 1'b0;
        is_ctrl_op     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: hand-encoded RV32I words with hand-computed
// expected decode, hazard, redirect and reset behaviour.
module tb_id_stage;
  import core_pkg::*;

  logic        clock;
  logic        reset;
  logic        alu_result_valid_ip;
  logic        wb_we_ip;
  logic [4:0]  wb_rd_ip;
  logic [31:0] wb_data_ip;
  logic        id_valid_op;
  logic [31:0] pc_addr_op, rs1_data_op, rs2_data_op, imm_op;
  logic [4:0]  rd_op;
  logic [3:0]  alu_op_op;
  logic [2:0]  funct3_op;
  logic        alu_src_imm_op, mem_read_op, mem_write_op, reg_write_op, is_ctrl_op;

  int checks   = 0;
  int failures = 0;

  id_stage_if bus ();

  id_stage dut (
    .clock               (clock),
    .reset               (reset),
    .fetch_bus           (bus),
    .alu_result_valid_ip (alu_result_valid_ip),
    .wb_we_ip            (wb_we_ip),
    .wb_rd_ip            (wb_rd_ip),
    .wb_data_ip          (wb_data_ip),
    .id_valid_op         (id_valid_op),
    .pc_addr_op          (pc_addr_op),
    .rs1_data_op         (rs1_data_op),
    .rs2_data_op         (rs2_data_op),
    .imm_op              (imm_op),
    .rd_op               (rd_op),
    .alu_op_op           (alu_op_op),
    .funct3_op           (funct3_op),
    .alu_src_imm_op      (alu_src_imm_op),
    .mem_read_op         (mem_read_op),
    .mem_write_op        (mem_write_op),
    .reg_write_op        (reg_write_op),
    .is_ctrl_op          (is_ctrl_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic present(input logic v, input logic [31:0] word, input logic [31:0] pc);
    bus.instr_valid_ip   = v;
    bus.instr_data_ip    = word;
    bus.instr_pc_addr_ip = pc;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    alu_result_valid_ip = 1'b0;
    wb_we_ip = 1'b0; wb_rd_ip = 5'd0; wb_data_ip = 32'd0;
    bus.instr_valid_ip = 1'b0; bus.instr_data_ip = 32'd0; bus.instr_pc_addr_ip = 32'd0;
    tick(); tick();
    chk("rst_pc_mux", 32'(bus.pc_mux_op), 32'(NEXTPC));
    chk("rst_stall", 32'(bus.stall_op), 32'd0);
    chk("rst_flush", 32'(bus.flush_op), 32'd0);
    chk("rst_valid", 32'(id_valid_op), 32'd0);
    chk("rst_imm", imm_op, 32'd0);
    reset = 1'b0;

    // ADDI x1,x0,5
    present(1'b1, 32'h0050_0093, 32'h0); tick();
    chk("addi_valid", 32'(id_valid_op), 32'd1);
    chk("addi_rd", 32'(rd_op), 32'd1);
    chk("addi_imm", imm_op, 32'd5);
    chk("addi_src_imm", 32'(alu_src_imm_op), 32'd1);
    chk("addi_reg_write", 32'(reg_write_op), 32'd1);
    chk("addi_alu_op", 32'(alu_op_op), 32'd0);

    // ADD x4,x3,x0 with same-cycle write-back x3 = DEADBEEF
    wb_we_ip = 1'b1; wb_rd_ip = 5'd3; wb_data_ip = 32'hDEAD_BEEF;
    present(1'b1, 32'h0001_8233, 32'h4); tick();
    chk("bypass_rs1", rs1_data_op, 32'hDEAD_BEEF);
    chk("add_rd", 32'(rd_op), 32'd4);
    chk("add_src_imm", 32'(alu_src_imm_op), 32'd0);
    wb_we_ip = 1'b0;
    // ADD x4,x0,x3 reads x3 from the array
    present(1'b1, 32'h0030_0233, 32'h8); tick();
    chk("rf_rs2", rs2_data_op, 32'hDEAD_BEEF);
    // ADD x4,x0,x0 while writing x0
    wb_we_ip = 1'b1; wb_rd_ip = 5'd0; wb_data_ip = 32'h1234_5678;
    present(1'b1, 32'h0000_0233, 32'hC); tick();
    chk("x0_no_bypass", rs1_data_op, 32'd0);
    wb_we_ip = 1'b0;
    tick();
    chk("x0_after_write", rs1_data_op, 32'd0);

    // SUB, SRAI, negative ADDI, SW, LUI
    present(1'b1, 32'h4020_8333, 32'h10); tick();
    chk("sub_alu_op", 32'(alu_op_op), 32'h8);
    present(1'b1, 32'h4030_D393, 32'h14); tick();
    chk("srai_alu_op", 32'(alu_op_op), 32'hD);
    chk("srai_imm", imm_op, 32'h0000_0403);
    present(1'b1, 32'hFFF0_0093, 32'h18); tick();
    chk("addi_neg_imm", imm_op, 32'hFFFF_FFFF);
    chk("addi_neg_alu_op", 32'(alu_op_op), 32'd0);
    present(1'b1, 32'h0020_A423, 32'h1C); tick();
    chk("sw_imm", imm_op, 32'd8);
    chk("sw_mem_write", 32'(mem_write_op), 32'd1);
    chk("sw_reg_write", 32'(reg_write_op), 32'd0);
    chk("sw_funct3", 32'(funct3_op), 32'd2);
    present(1'b1, 32'h1234_5437, 32'h20); tick();
    chk("lui_imm", imm_op, 32'h1234_5000);

    // LW x2,0(x1) then ADD x5,x2,x2: one-cycle load-use stall
    present(1'b1, 32'h0000_A103, 32'h24); tick();
    chk("lw_mem_read", 32'(mem_read_op), 32'd1);
    chk("lw_rd", 32'(rd_op), 32'd2);
    present(1'b1, 32'h0021_02B3, 32'h28);
    chk("lu_stall", 32'(bus.stall_op), 32'd1);
    tick();
    chk("lu_bubble_valid", 32'(id_valid_op), 32'd0);
    chk("lu_bubble_mem_read", 32'(mem_read_op), 32'd0);
    chk("lu_stall_released", 32'(bus.stall_op), 32'd0);
    tick();
    chk("lu_issue_valid", 32'(id_valid_op), 32'd1);
    chk("lu_issue_rd", 32'(rd_op), 32'd5);

    // LW x0 then a consumer of x0: no stall
    present(1'b1, 32'h0000_A003, 32'h2C); tick();
    present(1'b1, 32'h0000_02B3, 32'h30);
    chk("x0_no_stall", 32'(bus.stall_op), 32'd0);
    tick();
    chk("x0_consumer_valid", 32'(id_valid_op), 32'd1);

    // alu_result_valid in RUN is ignored
    alu_result_valid_ip = 1'b1;
    present(1'b1, 32'h0050_0093, 32'h34); tick();
    alu_result_valid_ip = 1'b0;
    present(1'b1, 32'h0050_0093, 32'h38);
    chk("run_ignore_pc_mux", 32'(bus.pc_mux_op), 32'(NEXTPC));
    tick();
    chk("run_ignore_valid", 32'(id_valid_op), 32'd1);

    // BEQ x1,x2,-8 at 0x10, two wrong-path squashes, one drain bubble
    present(1'b1, 32'hFE20_8CE3, 32'h10);
    chk("beq_pc_mux_issue", 32'(bus.pc_mux_op), 32'(ALU_RESULT));
    tick();
    chk("beq_ctrl", 32'(is_ctrl_op), 32'd1);
    chk("beq_imm", imm_op, 32'hFFFF_FFF8);
    chk("beq_pc", pc_addr_op, 32'h10);
    chk("beq_valid", 32'(id_valid_op), 32'd1);
    present(1'b1, 32'h0050_0093, 32'h14);
    chk("wait_pc_mux", 32'(bus.pc_mux_op), 32'(ALU_RESULT));
    tick();
    chk("wrong_path1", 32'(id_valid_op), 32'd0);
    alu_result_valid_ip = 1'b1;
    present(1'b1, 32'h0050_0093, 32'h18);
    chk("wait_pc_mux_tgt", 32'(bus.pc_mux_op), 32'(ALU_RESULT));
    tick();
    chk("wrong_path2", 32'(id_valid_op), 32'd0);
    alu_result_valid_ip = 1'b0;
    present(1'b1, 32'h0050_0093, 32'h1C);
    chk("drain_pc_mux", 32'(bus.pc_mux_op), 32'(NEXTPC));
    tick();
    chk("drain_bubble", 32'(id_valid_op), 32'd0);
    present(1'b1, 32'h0050_0093, 32'h08); tick();
    chk("target_valid", 32'(id_valid_op), 32'd1);
    chk("target_pc", pc_addr_op, 32'h08);

    // Illegal word: one-cycle flush and a bubble
    present(1'b1, 32'hFFFF_FFFF, 32'h0C);
    chk("ill_flush", 32'(bus.flush_op), 32'd1);
    chk("ill_no_stall", 32'(bus.stall_op), 32'd0);
    tick();
    chk("ill_bubble", 32'(id_valid_op), 32'd0);
    present(1'b0, 32'h0050_0093, 32'h10);
    chk("ill_flush_one_cycle", 32'(bus.flush_op), 32'd0);
    tick();
    chk("invalid_bubble", 32'(id_valid_op), 32'd0);

    // Ctrl under load-use hazard stalls, then issues; reset in WAIT_TGT
    present(1'b1, 32'h0000_A103, 32'h40); tick();
    present(1'b1, 32'hFE20_8CE3, 32'h44);
    chk("ctrl_hz_stall", 32'(bus.stall_op), 32'd1);
    chk("ctrl_hz_pc_mux", 32'(bus.pc_mux_op), 32'(NEXTPC));
    tick();
    chk("ctrl_hz_bubble", 32'(id_valid_op), 32'd0);
    chk("ctrl_hz_pc_mux_issue", 32'(bus.pc_mux_op), 32'(ALU_RESULT));
    tick();
    chk("ctrl_hz_issued", 32'(is_ctrl_op), 32'd1);
    chk("ctrl_hz_pc", pc_addr_op, 32'h44);
    reset = 1'b1;
    tick();
    chk("rst_wait_valid", 32'(id_valid_op), 32'd0);
    chk("rst_wait_ctrl", 32'(is_ctrl_op), 32'd0);
    chk("rst_wait_pc", pc_addr_op, 32'd0);
    chk("rst_wait_imm", imm_op, 32'd0);
    reset = 1'b0;
    present(1'b0, 32'd0, 32'd0);
    chk("rst_wait_pc_mux", 32'(bus.pc_mux_op), 32'(NEXTPC));

    // Register file cleared by reset: x3 reads zero again
    present(1'b1, 32'h0001_8233, 32'h0); tick();
    chk("rf_cleared_valid", 32'(id_valid_op), 32'd1);
    chk("rf_cleared_x3", rs1_data_op, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Decode stage of the 5-stage RV32I pipeline, directly downstream of instruction fetch.
- Consumes the IF/ID buffer (valid, instruction word, PC).
- Decodes the instruction, reads the 32x32 register file, and writes it from write-back.
- Detects load-use hazards and tracks control-flow redirects.
- Drives pc_mux/stall/flush back to fetch and registers the ID/EX pipeline buffer.

Parameters:
- NUM_REGS, 32, register file depth; x0 hardwired to zero.
- RESET_REGS, 1, when 1 the register file clears to zero on reset.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- instr_valid_ip  in  1  IF/ID buffer holds a valid instruction.
- instr_data_ip  in  32  instruction word.
- instr_pc_addr_ip  in  32  PC of the instruction.
- alu_result_valid_ip  in  1  EX has produced the redirect target.
- wb_we_ip  in  1  write-back enable.
- wb_rd_ip  in  5  write-back destination.
- wb_data_ip  in  32  write-back data.
- pc_mux_op  out  pc_mux (CORE_PKG)  next-PC select to fetch.
- stall_op  out  1  hold fetch PC and IF/ID buffer.
- flush_op  out  1  clear IF/ID buffer and restart fetch at PC 0.
- id_valid_op  out  1  ID/EX holds a real instruction; 0 means bubble.
- pc_addr_op  out  32  PC of the issued instruction.
- rs1_data_op, rs2_data_op  out  32 each  operand values.
- imm_op  out  32  sign-extended immediate.
- rd_op  out  5  destination register.
- alu_op_op  out  4  {funct7[5], funct3}; 0000 (ADD) for non-arithmetic.
- funct3_op  out  3  raw funct3, used for branch compare and load/store size.
- alu_src_imm_op, mem_read_op, mem_write_op, reg_write_op, is_ctrl_op  out  1 each  control bits.

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high.
- Reset values:
  - All ID/EX outputs 0.
  - FSM in RUN.
  - Register file zeroed when RESET_REGS=1.
  - Combinational outputs evaluate to pc_mux_op=NEXTPC, stall_op=0, flush_op=0.
- Decoded opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP. Any other opcode with instr_valid_ip=1 is illegal.
- Immediates (I/S/B/U/J formats):
  - Built per the RISC-V spec and sign-extended to 32 bits.
  - B and J immediates have bit 0 = 0.
- alu_op rules:
  - OP: alu_op = {funct7[5], funct3}.
  - OP-IMM: alu_op = {funct7[5] only when funct3=101, funct3}.
- is_ctrl_op is set for JAL, JALR and BRANCH.
  - EX resolves the target and drives alu_result_valid_ip.
  - For a not-taken branch, EX supplies pc+4 as the result.
- Register read:
  - Combinational read; x0 always reads 0.
  - Write-first bypass: if wb_we_ip and wb_rd_ip matches a nonzero rs, the operand is wb_data_ip in the same cycle.
  - Writes to x0 are ignored.
- Load-use hazard:
  - Condition: ID/EX holds mem_read=1 with rd≠0, and the current valid instruction reads that rd. Reads are rs1 for all but LUI/AUIPC/JAL; rs2 for BRANCH/STORE/OP.
  - Response: stall_op=1 and a bubble is inserted into ID/EX (id_valid_op=0, all control bits 0).
  - Stalls exactly 1 cycle.
- FSM states:
  - RUN: normal decode, pc_mux_op=NEXTPC.
    - Valid ctrl instruction, no hazard: issue it, pc_mux_op=ALU_RESULT this cycle, next state WAIT_TGT.
    - Valid illegal instruction: flush_op=1 for one cycle, issue a bubble, stay in RUN.
  - WAIT_TGT: pc_mux_op=ALU_RESULT; the incoming instruction is wrong-path and is squashed (bubble).
    - alu_result_valid_ip=1: next state DRAIN.
  - DRAIN: pc_mux_op=NEXTPC; the incoming instruction (fetched pre-redirect) is squashed; next state RUN.
- Priority:
  - reset > illegal flush > load-use stall > ctrl issue.
  - A ctrl instruction under a hazard stalls first and issues on the following cycle.
- Boundary rules:
  - instr_valid_ip=0 issues a bubble with no hazard or FSM action.
  - A stall never occurs in WAIT_TGT/DRAIN, because squashed instructions are ignored for hazards.
  - Reset mid-WAIT_TGT returns to RUN and clears ID/EX.
  - alu_result_valid_ip in RUN is ignored.
- Latency: one cycle from IF/ID to ID/EX.

Test Plan:
- Reset, then ADDI x1,x0,5 at PC 0x0 → next cycle id_valid_op=1, rd_op=1, imm_op=5, alu_src_imm_op=1, reg_write_op=1.
- Write-back x3=0xDEADBEEF in the same cycle as decode of ADD x4,x3,x0 → rs1_data_op=0xDEADBEEF; read of x0 returns 0 even after a write to x0.
- LW x2,0(x1) followed by ADD x5,x2,x2 → stall_op=1 for exactly one cycle, a bubble issued, then ADD issued; no stall for a consumer of rd=x0.
- BEQ at PC 0x10 with imm −8 → imm_op=0xFFFFFFF8, is_ctrl_op=1, pc_mux_op=ALU_RESULT; two wrong-path instructions squashed until alu_result_valid_ip, then one DRAIN bubble, then RUN.
- Instruction word 0xFFFFFFFF valid → flush_op=1 for one cycle, bubble issued; reset asserted during WAIT_TGT → all ID/EX outputs 0, pc_mux_op=NEXTPC.
